demux_pair: RTL and testbench
=============================

Name: demux_pair

Overview:
- Inverse of the team's 2:1 lane mux.
- Takes one serialized byte stream (lane 0 byte first, then lane 1 byte) and rebuilds the two parallel lanes.
- Emits each lane-0/lane-1 pair on the same cycle.
- Sits between the serial link and the lane consumers; a timeout flushes an orphan lane-0 byte so a broken stream cannot stall.

Parameters:
- DATA_WIDTH, 8, width of every data bus.
- HOLD_TIMEOUT, 4, cycles to wait for the lane-1 byte before flushing lane 0 alone; 0 disables the timeout.
- CNT_WIDTH, 3, width of the timeout counter; must hold HOLD_TIMEOUT.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  DATA_WIDTH  serialized byte
- valid_in  input  1  data_in valid this cycle
- data_out_0  output  DATA_WIDTH  lane-0 byte
- valid_out_0  output  1  data_out_0 valid (one-cycle pulse)
- data_out_1  output  DATA_WIDTH  lane-1 byte
- valid_out_1  output  1  data_out_1 valid (one-cycle pulse)
- orphan  output  1  pulse: lane-0 byte was flushed by timeout, no partner

Behaviour:
- One clock; reset is asynchronous and active-low (reset_L).
- Reset (reset_L=0, asynchronous assert, synchronous-edge release):
  - state=WAIT0, hold_reg=0, timeout counter=0.
  - data_out_0=0, data_out_1=0, valid_out_0=0, valid_out_1=0, orphan=0.
- FSM, two states:
  - WAIT0: no lane-0 byte held. On valid_in=1, hold_reg<=data_in, counter<=0, go WAIT1. On valid_in=0, stay.
  - WAIT1: lane-0 byte held.
    - On valid_in=1: data_out_0<=hold_reg, data_out_1<=data_in, valid_out_0<=1, valid_out_1<=1, go WAIT0.
    - On valid_in=0: counter<=counter+1.
    - If HOLD_TIMEOUT!=0 and counter==HOLD_TIMEOUT-1 with valid_in=0: data_out_0<=hold_reg, valid_out_0<=1, valid_out_1<=0, orphan<=1, go WAIT0.
- Valid outputs and orphan are registered pulses, high exactly one cycle per event, default 0.
- Data outputs hold their last value when valid is low; they are never cleared except by reset.
- Latency:
  - Lane-1 byte: 1 cycle after its valid_in cycle.
  - Lane-0 byte: appears the same cycle as its partner.
  - Timeout: orphan flush appears HOLD_TIMEOUT cycles after the last lane-0 input cycle.
- Back-to-back pairs at full rate (valid_in every cycle) yield one valid pair every 2 cycles; no input is ever dropped.
- Gaps of valid_in=0 in WAIT0 change nothing.
- Gaps in WAIT1 shorter than HOLD_TIMEOUT are tolerated; the pair is still formed.
- Simultaneous timeout expiry and valid_in=1: valid_in wins, the pair is formed normally, orphan=0.
- After an orphan flush, the next valid byte is treated as lane 0 (resynchronises to WAIT0).
- Reset mid-pair (WAIT1): the held byte is discarded; no output pulse is produced.
- Counter saturates; it never wraps while in WAIT1.
- No backpressure: consumers must accept every pulse.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: WAIT0=1'b0, WAIT1=1'b1.
  - Default DATA_WIDTH.
  - Default HOLD_TIMEOUT.
- A single flat module; no sub-module is natural (FSM, hold register and counter are all small).
- A synthesized netlist variant (demux_pair_synth) is generated from the RTL and compared against it in the bench, as for the mux.

Test Plan:
- Reset: reset_L=0 for 2 cycles with valid_in toggling -> all outputs 0, orphan 0. Then release.
- Full-rate stream 0xA1,0xB2,0xC3,0xD4 on 4 consecutive cycles:
  - Cycle after 0xB2: data_out_0=0xA1, data_out_1=0xB2, both valid.
  - Cycle after 0xD4: 0xC3/0xD4, both valid.
  - Valid low on the cycles between.
- Gap tolerance: 0x11, 2 idle cycles, 0x22 -> one pair 0x11/0x22, both valid one cycle after 0x22, orphan=0.
- Timeout: 0x55 then 4 idle cycles (HOLD_TIMEOUT=4):
  - data_out_0=0x55, valid_out_0=1, valid_out_1=0, orphan=1 for one cycle.
  - Next bytes 0x66,0x77 pair as 0x66/0x77.
- Simultaneous event: 0x33, 3 idle cycles, then 0x44 on the expiry cycle -> pair 0x33/0x44, orphan=0.
- Reset mid-pair: 0x99 then reset_L=0 one cycle -> no output pulse. After release, 0x01,0x02 pair as 0x01/0x02.
- All scenarios: RTL and synthesized outputs compared cycle by cycle; any mismatch flagged.

Source files
------------

// File: rtl/demux_pair_pkg.sv
// Shared definitions for the lane demultiplexer: FSM state encodings and
// default sizing parameters.
package demux_pair_pkg;

  // Lane-pair assembly states.
  typedef enum logic {
    WAIT0 = 1'b0,  // no lane-0 byte held
    WAIT1 = 1'b1   // lane-0 byte held, waiting for its lane-1 partner
  } state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
  localparam int unsigned DEFAULT_HOLD_TIMEOUT = 4;
  localparam int unsigned DEFAULT_CNT_WIDTH    = 3;

endpackage : demux_pair_pkg

// File: rtl/demux_pair.sv
// demux_pair: rebuilds two parallel lanes from a serialized byte stream that
// alternates lane 0, lane 1. Each lane-0/lane-1 pair is emitted on the same
// cycle. A lane-0 byte left without a partner for HOLD_TIMEOUT idle cycles
// is flushed alone and flagged with orphan, so a broken stream cannot stall.
//
// Ports:
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset
//   data_in      serialized byte
//   valid_in     data_in valid this cycle
//   data_out_0   lane-0 byte (holds last value)
//   valid_out_0  one-cycle pulse, data_out_0 valid
//   data_out_1   lane-1 byte (holds last value)
//   valid_out_1  one-cycle pulse, data_out_1 valid
//   orphan       one-cycle pulse, lane-0 byte flushed without partner
module demux_pair
  import demux_pair_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned HOLD_TIMEOUT = DEFAULT_HOLD_TIMEOUT,
  parameter int unsigned CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic                  valid_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  valid_out_1,
  output logic                  orphan
);

  // A zero timeout disables the flush; the counter then just saturates.
  localparam logic                 TIMEOUT_EN = (HOLD_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT   =
    TIMEOUT_EN ? CNT_WIDTH'(HOLD_TIMEOUT - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_out_0_d, data_out_1_d;
  logic                    valid_out_0_d, valid_out_1_d, orphan_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    cnt_d         = cnt_q;
    data_out_0_d  = data_out_0;
    data_out_1_d  = data_out_1;
    valid_out_0_d = 1'b0;
    valid_out_1_d = 1'b0;
    orphan_d      = 1'b0;

    case (state_q)
      WAIT0: begin
        if (valid_in) begin
          hold_d  = data_in;
          cnt_d   = '0;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        // An arriving partner always wins over a timeout on the same cycle.
        if (valid_in) begin
          data_out_0_d  = hold_q;
          data_out_1_d  = data_in;
          valid_out_0_d = 1'b1;
          valid_out_1_d = 1'b1;
          state_d       = WAIT0;
        end else if (TIMEOUT_EN && (cnt_q == LAST_CNT)) begin
          data_out_0_d  = hold_q;
          valid_out_0_d = 1'b1;
          orphan_d      = 1'b1;
          state_d       = WAIT0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, hold register, counter and output registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= WAIT0;
      hold_q      <= '0;
      cnt_q       <= '0;
      data_out_0  <= '0;
      data_out_1  <= '0;
      valid_out_0 <= 1'b0;
      valid_out_1 <= 1'b0;
      orphan      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      data_out_0  <= data_out_0_d;
      data_out_1  <= data_out_1_d;
      valid_out_0 <= valid_out_0_d;
      valid_out_1 <= valid_out_1_d;
      orphan      <= orphan_d;
    end
  end

endmodule : demux_pair

// File: tb/tb_demux_pair.sv
// Bench for demux_pair: directed scenarios followed by random traffic, all
// checked against a pairing model that tracks the held byte and idle time.
module tb_demux_pair;

  localparam int unsigned DW = 8;
  localparam int unsigned HT = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [DW-1:0] data_out_0;
  logic          valid_out_0;
  logic [DW-1:0] data_out_1;
  logic          valid_out_1;
  logic          orphan;

  demux_pair #(
    .DATA_WIDTH  (DW),
    .HOLD_TIMEOUT(HT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out_0 (data_out_0),
    .valid_out_0(valid_out_0),
    .data_out_1 (data_out_1),
    .valid_out_1(valid_out_1),
    .orphan     (orphan)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: is a lane-0 byte waiting, what it is, how long idle.
  bit          m_held;
  logic [DW-1:0] m_byte;
  int          m_idle;
  logic [DW-1:0] e_d0, e_d1;
  bit          e_v0, e_v1, e_orph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_byte = '0; m_idle = 0;
    e_d0 = '0; e_d1 = '0; e_v0 = 1'b0; e_v1 = 1'b0; e_orph = 1'b0;
  endtask

  // Expected outputs for the cycle after an input beat.
  task automatic model_step(input bit v, input logic [DW-1:0] d);
    e_v0 = 1'b0; e_v1 = 1'b0; e_orph = 1'b0;
    if (!m_held) begin
      if (v) begin
        m_held = 1'b1; m_byte = d; m_idle = 0;
      end
    end else if (v) begin
      e_d0 = m_byte; e_d1 = d; e_v0 = 1'b1; e_v1 = 1'b1; m_held = 1'b0;
    end else begin
      m_idle++;
      if (HT != 0 && m_idle == int'(HT)) begin
        e_d0 = m_byte; e_v0 = 1'b1; e_orph = 1'b1; m_held = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_out_0"}, 32'(valid_out_0), 32'(e_v0));
    chk({tag, ".valid_out_1"}, 32'(valid_out_1), 32'(e_v1));
    chk({tag, ".orphan"},      32'(orphan),      32'(e_orph));
    chk({tag, ".data_out_0"},  32'(data_out_0),  32'(e_d0));
    chk({tag, ".data_out_1"},  32'(data_out_1),  32'(e_d1));
  endtask

  task automatic step(input string tag, input bit v, input logic [DW-1:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    model_step(v, d);
    check_all(tag);
  endtask

  task automatic reset_cycles(input string tag, input int n);
    reset_L = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      valid_in = ~valid_in;
      data_in  = DW'($urandom);
      @(posedge clk);
      #1;
      check_all(tag);
    end
    reset_L  = 1'b1;
    valid_in = 1'b0;
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();

    // Reset with valid_in toggling.
    reset_cycles("reset", 2);
    step("idle", 1'b0, 8'h00);

    // Full-rate stream.
    step("fr_a1", 1'b1, 8'hA1);
    step("fr_b2", 1'b1, 8'hB2);
    chk("fr_pair0_d0", 32'(data_out_0), 32'h A1);
    chk("fr_pair0_d1", 32'(data_out_1), 32'h B2);
    step("fr_c3", 1'b1, 8'hC3);
    step("fr_d4", 1'b1, 8'hD4);
    chk("fr_pair1_d0", 32'(data_out_0), 32'h C3);
    chk("fr_pair1_d1", 32'(data_out_1), 32'h D4);
    step("fr_idle", 1'b0, 8'h00);

    // Gap tolerance.
    step("gap_11", 1'b1, 8'h11);
    step("gap_i0", 1'b0, 8'h00);
    step("gap_i1", 1'b0, 8'h00);
    step("gap_22", 1'b1, 8'h22);
    chk("gap_pair_v1", 32'(valid_out_1), 32'h1);

    // Timeout flush after HT idle cycles, then resync.
    step("to_55", 1'b1, 8'h55);
    for (int i = 0; i < int'(HT) - 1; i++) step("to_wait", 1'b0, 8'h00);
    step("to_flush", 1'b0, 8'h00);
    chk("to_orphan", 32'(orphan), 32'h1);
    chk("to_d0", 32'(data_out_0), 32'h55);
    step("to_66", 1'b1, 8'h66);
    step("to_77", 1'b1, 8'h77);
    chk("to_resync_d0", 32'(data_out_0), 32'h66);

    // Partner arrives on the expiry cycle.
    step("sim_33", 1'b1, 8'h33);
    for (int i = 0; i < int'(HT) - 1; i++) step("sim_wait", 1'b0, 8'h00);
    step("sim_44", 1'b1, 8'h44);
    chk("sim_orphan", 32'(orphan), 32'h0);
    chk("sim_d1", 32'(data_out_1), 32'h44);

    // Reset mid-pair discards the held byte.
    step("mid_99", 1'b1, 8'h99);
    reset_cycles("mid_reset", 1);
    step("mid_01", 1'b1, 8'h01);
    step("mid_02", 1'b1, 8'h02);
    chk("mid_pair_d0", 32'(data_out_0), 32'h01);

    // Random traffic with occasional long gaps and resets.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) reset_cycles("rnd_reset", 1);
      else if (r < 10) begin
        for (int k = 0; k < int'(HT) + 1; k++) step("rnd_gap", 1'b0, DW'($urandom));
      end else step("rnd", r < 60, DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_demux_pair
